comp_seq: RTL and testbench
===========================

COMP_SEQ -- requirements
Module: comp_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be at least 1.
REQ-002 Parameter CHUNK, default 4: bits compared per cycle; SHALL be at least 1 and divide WIDTH exactly; N = WIDTH/CHUNK.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port start, input, 1: request a compare; sampled only while idle.
REQ-007 Port signed_mode, input, 1: 1 = two's-complement compare, 0 = unsigned; latched with the operands.
REQ-008 Port A, input, WIDTH: operand A; latched on start acceptance.
REQ-009 Port B, input, WIDTH: operand B; latched on start acceptance.
REQ-010 Port busy, output, 1: compare in progress.
REQ-011 Port done, output, 1: one-cycle pulse marking a new valid result.
REQ-012 Port out_A_G_B, output, 1: latched result, A > B.
REQ-013 Port out_A_E_B, output, 1: latched result, A == B.
REQ-014 Port out_A_L_B, output, 1: latched result, A < B.

Function
REQ-015 States: IDLE and BUSY; a chunk index register idx spans 0..N-1.
REQ-016 In IDLE with start=1 at a rising edge E0:
- latch A, B and signed_mode;
- set idx = N-1;
- enter BUSY, so busy=1 from the next cycle.
REQ-017 In BUSY, each rising edge compares chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK) of the latched operands, most significant chunk first.
REQ-018 Signed mode applies only to chunk N-1: invert the MSB of both latched operands before comparing; all other chunks compare unsigned.
REQ-019 Chunk unequal: register gt or lt (one-hot, eq=0), pulse done=1 for exactly the next cycle, return to IDLE (early termination).
REQ-020 Chunk equal with idx>0: decrement idx and stay in BUSY; results and done unchanged.
REQ-021 Chunk equal with idx=0: register eq=1 (gt=lt=0), pulse done, return to IDLE.
REQ-022 Latency from E0 to the edge that raises done = k cycles, where k = number of chunks examined (1..N):
- k = 1 when the top chunk differs;
- k = N when A == B.
REQ-023 busy=1 exactly during the k cycles after E0; busy=0 in the cycle done=1.
REQ-024 Result outputs hold their last registered value until the next done; the inputs A, B and signed_mode have no effect while BUSY.
REQ-025 start while BUSY is ignored; it is not queued.
REQ-026 start=1 in the same cycle that done=1 is accepted; the state is IDLE then.
REQ-027 After any done, exactly one of out_A_G_B, out_A_E_B, out_A_L_B is 1.
REQ-028 CHUNK=WIDTH is legal: every compare completes with k=1.

Reset
REQ-029 rst=1 at a rising edge forces IDLE, idx=N-1, and busy=done=out_A_G_B=out_A_E_B=out_A_L_B=0; rst has priority over start.
REQ-030 rst during BUSY aborts the compare with no done pulse; a start on the first cycle after rst deasserts is accepted normally.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-031 A=16'h1234, B=16'h1234, unsigned, start -> busy for 4 cycles, done at cycle 4, eq=1 gt=0 lt=0.
REQ-032 A=16'h8000, B=16'h7FFF, start -> unsigned: gt=1 with done at cycle 1; repeated with signed_mode=1: lt=1 with done at cycle 1.
REQ-033 A=16'h1235, B=16'h1234 -> gt=1 at cycle 4; then A=16'h1034, B=16'h1234 -> lt=1 at cycle 2.
REQ-034 Start held high continuously with A/B changed mid-compare -> each result reflects the operands latched at acceptance; back-to-back accept on each done cycle; no accept while busy.
REQ-035 rst asserted at cycle 2 of a 4-chunk equal compare -> no done pulse, all outputs 0 the cycle after rst; subsequent compare correct.
REQ-036 WIDTH=8, CHUNK=8, signed: A=8'hFF, B=8'h01 -> lt=1, done at cycle 1; random self-checking compare against a reference model for both configurations.

Source files
------------

// File: rtl/comp_seq_if.sv
// Bundle of the comp_seq request and result signals.
// The requester drives operands and start; the comparator returns status and result flags.
interface comp_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             out_A_G_B;
  logic             out_A_E_B;
  logic             out_A_L_B;

  modport master (
    output start, signed_mode, A, B,
    input  busy, done, out_A_G_B, out_A_E_B, out_A_L_B
  );

  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, out_A_G_B, out_A_E_B, out_A_L_B
  );
endinterface

// File: rtl/comp_seq.sv
// Sequential magnitude comparator: walks the operands CHUNK bits per cycle, most significant
// chunk first, and stops on the first unequal chunk. Supports unsigned and two's-complement.
module comp_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic      clk,
  input  logic      rst,
  comp_seq_if.slave bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             done_q, done_d;

  logic [N-1:0][CHUNK-1:0] a_ch;
  logic [N-1:0][CHUNK-1:0] b_ch;
  logic [CHUNK-1:0]        chunk_a;
  logic [CHUNK-1:0]        chunk_b;

  assign a_ch    = a_q;
  assign b_ch    = b_q;
  assign chunk_a = a_ch[idx_q];
  assign chunk_b = b_ch[idx_q];

  // Signed compare is done by flipping both sign bits at latch time. That turns two's-complement
  // ordering into unsigned ordering, so every chunk, including the top one, compares unsigned.
  // NOTE: every variable gets its default at the top of the block, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.signed_mode ? (bus.A ^ MSB_MASK) : bus.A;
          b_d     = bus.signed_mode ? (bus.B ^ MSB_MASK) : bus.B;
          idx_d   = IDX_TOP;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        if (chunk_a != chunk_b) begin
          gt_d    = (chunk_a > chunk_b);
          lt_d    = (chunk_a < chunk_b);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (idx_q == '0) begin
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_TOP;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      done_q  <= done_d;
    end
  end

  // NOTE: operand registers are deliberately left out of reset; they are always reloaded on
  // start before being read, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.busy      = (state_q == S_BUSY);
  assign bus.done      = done_q;
  assign bus.out_A_G_B = gt_q;
  assign bus.out_A_E_B = eq_q;
  assign bus.out_A_L_B = lt_q;

endmodule

// File: tb/tb_comp_seq.sv
// Scoreboard bench for comp_seq: a 16-bit/4-bit-chunk instance and an 8-bit single-chunk instance.
// Expected results and latencies come from an integer reference model, queued at acceptance.
module tb_comp_seq;

  localparam int N16 = 4;
  localparam int N8  = 1;

  typedef struct {
    bit gt;
    bit eq;
    bit lt;
    int k;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb16[$];
  exp_t sb8[$];

  comp_seq_if #(.WIDTH(16)) b16 ();
  comp_seq_if #(.WIDTH(8))  b8 ();

  comp_seq #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  comp_seq #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input bit sgn,
                                 input int w, input int ch);
    exp_t        r;
    longint      va, vb;
    int          n;
    logic [15:0] m, ca, cb;
    n  = w / ch;
    va = longint'(a);
    vb = longint'(b);
    if (sgn && a[w-1]) va = va - (longint'(1) << w);
    if (sgn && b[w-1]) vb = vb - (longint'(1) << w);
    r.gt = (va > vb);
    r.eq = (va == vb);
    r.lt = (va < vb);
    m    = 16'((32'd1 << ch) - 1);
    r.k  = n;
    for (int i = n - 1; i >= 0; i--) begin
      ca = (a >> (i * ch)) & m;
      cb = (b >> (i * ch)) & m;
      if (ca != cb) begin
        r.k = n - i;
        break;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request on an idle 16-bit DUT; returns one cycle after the accepting edge.
  task automatic start16(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    b16.A           = a;
    b16.B           = b;
    b16.signed_mode = sgn;
    b16.start       = 1'b1;
    sb16.push_back(model(a, b, sgn, 16, 4));
    tick();
    b16.start = 1'b0;
  endtask

  // Called in cycle 1 after acceptance; returns in the done cycle after checking the result.
  task automatic wait16();
    exp_t e;
    int   lat;
    bit   got;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i <= N16 + 2; i++) begin
      if (b16.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      checks++;
      if (b16.busy !== 1'b1) begin
        errors++;
        $display("FAIL busy16_during_compare: got %b want 1 (cycle %0d)", b16.busy, lat + 1);
      end
      lat++;
      tick();
    end
    checks++;
    if (!got || sb16.size() == 0) begin
      errors++;
      $display("FAIL done16_timeout: got done=%b, queued=%0d, want done within %0d cycles",
               b16.done, sb16.size(), N16);
      if (sb16.size() != 0) void'(sb16.pop_front());
      return;
    end
    e = sb16.pop_front();
    if (lat !== e.k) begin
      errors++;
      $display("FAIL latency16: got %0d want %0d", lat, e.k);
    end
    checks++;
    if ({b16.out_A_G_B, b16.out_A_E_B, b16.out_A_L_B} !== {e.gt, e.eq, e.lt}) begin
      errors++;
      $display("FAIL result16 gt/eq/lt: got %b%b%b want %b%b%b", b16.out_A_G_B, b16.out_A_E_B,
               b16.out_A_L_B, e.gt, e.eq, e.lt);
    end
    checks++;
    if (b16.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy16_in_done_cycle: got %b want 0", b16.busy);
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    start16(a, b, sgn);
    wait16();
    tick();
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    exp_t e;
    int   lat;
    bit   got;
    b8.A           = a;
    b8.B           = b;
    b8.signed_mode = sgn;
    b8.start       = 1'b1;
    sb8.push_back(model({8'h00, a}, {8'h00, b}, sgn, 8, 8));
    tick();
    b8.start = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i <= N8 + 2; i++) begin
      if (b8.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      lat++;
      tick();
    end
    checks++;
    if (!got || sb8.size() == 0) begin
      errors++;
      $display("FAIL done8_timeout: got done=%b want done within %0d cycles", b8.done, N8);
      if (sb8.size() != 0) void'(sb8.pop_front());
      tick();
      return;
    end
    e = sb8.pop_front();
    if (lat !== e.k) begin
      errors++;
      $display("FAIL latency8: got %0d want %0d (A=%h B=%h s=%b)", lat, e.k, a, b, sgn);
    end
    checks++;
    if ({b8.out_A_G_B, b8.out_A_E_B, b8.out_A_L_B} !== {e.gt, e.eq, e.lt}) begin
      errors++;
      $display("FAIL result8 gt/eq/lt: got %b%b%b want %b%b%b (A=%h B=%h s=%b)", b8.out_A_G_B,
               b8.out_A_E_B, b8.out_A_L_B, e.gt, e.eq, e.lt, a, b, sgn);
    end
    tick();
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    b16.start      = 1'b0;
    b16.signed_mode = 1'b0;
    b16.A          = '0;
    b16.B          = '0;
    b8.start       = 1'b0;
    b8.signed_mode = 1'b0;
    b8.A           = '0;
    b8.B           = '0;
    repeat (3) tick();
    checks++;
    if ({b16.busy, b16.done, b16.out_A_G_B, b16.out_A_E_B, b16.out_A_L_B} !== 5'b0) begin
      errors++;
      $display("FAIL reset16 outputs: got %b%b%b%b%b want 00000", b16.busy, b16.done,
               b16.out_A_G_B, b16.out_A_E_B, b16.out_A_L_B);
    end
    checks++;
    if ({b8.busy, b8.done, b8.out_A_G_B, b8.out_A_E_B, b8.out_A_L_B} !== 5'b0) begin
      errors++;
      $display("FAIL reset8 outputs: got %b%b%b%b%b want 00000", b8.busy, b8.done,
               b8.out_A_G_B, b8.out_A_E_B, b8.out_A_L_B);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run16(16'h1234, 16'h1234, 1'b0);
    run16(16'h8000, 16'h7FFF, 1'b0);
    run16(16'h8000, 16'h7FFF, 1'b1);
    run16(16'h1235, 16'h1234, 1'b0);
    run16(16'h1034, 16'h1234, 1'b0);
  endtask

  task automatic test_signed_edges();
    run16(16'h7FFF, 16'h8000, 1'b1);
    run16(16'hFFFF, 16'hFFFF, 1'b1);
    run16(16'hFFFF, 16'h0000, 1'b1);
    run16(16'hFFFF, 16'h0000, 1'b0);
    run16(16'hFFFE, 16'hFFFF, 1'b1);
  endtask

  task automatic test_hold();
    run16(16'h1235, 16'h1234, 1'b0);
    b16.A           = 16'h0000;
    b16.B           = 16'hFFFF;
    b16.signed_mode = 1'b1;
    repeat (3) tick();
    checks++;
    if ({b16.busy, b16.done, b16.out_A_G_B, b16.out_A_E_B, b16.out_A_L_B} !== 5'b00100) begin
      errors++;
      $display("FAIL hold16 busy/done/gt/eq/lt: got %b%b%b%b%b want 00100", b16.busy, b16.done,
               b16.out_A_G_B, b16.out_A_E_B, b16.out_A_L_B);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] na, nb;
    bit          ns;
    b16.A           = 16'h1235;
    b16.B           = 16'h1234;
    b16.signed_mode = 1'b0;
    b16.start       = 1'b1;
    sb16.push_back(model(16'h1235, 16'h1234, 1'b0, 16, 4));
    tick();
    for (int op = 0; op < 5; op++) begin
      // Mid-compare: the operands on the bus now are the ones the next accept will latch.
      na = 16'($urandom);
      nb = (op % 2 == 0) ? {na[15:4], 4'($urandom)} : 16'($urandom);
      ns = 1'($urandom);
      b16.A           = na;
      b16.B           = nb;
      b16.signed_mode = ns;
      if (op == 4) b16.start = 1'b0;
      wait16();
      if (op < 4) sb16.push_back(model(na, nb, ns, 16, 4));
      tick();
    end
    checks++;
    if (b16.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_accept_when_start_low: busy got %b want 0", b16.busy);
    end
  endtask

  task automatic test_reset_abort();
    run16(16'h8000, 16'h7FFF, 1'b0);
    b16.A           = 16'h1234;
    b16.B           = 16'h1234;
    b16.signed_mode = 1'b0;
    b16.start       = 1'b1;
    tick();
    b16.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({b16.busy, b16.done, b16.out_A_G_B, b16.out_A_E_B, b16.out_A_L_B} !== 5'b0) begin
      errors++;
      $display("FAIL abort16 outputs after rst: got %b%b%b%b%b want 00000", b16.busy, b16.done,
               b16.out_A_G_B, b16.out_A_E_B, b16.out_A_L_B);
    end
    b16.start = 1'b1;
    tick();
    checks++;
    if (b16.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_priority_over_start: busy got %b want 0", b16.busy);
    end
    rst = 1'b0;
    start16(16'h1230, 16'h1234, 1'b0);
    wait16();
    tick();
  endtask

  task automatic test_chunk_equals_width();
    run8(8'hFF, 8'h01, 1'b1);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'h80, 8'h7F, 1'b1);
    run8(8'h5A, 8'h5A, 1'b1);
    for (int i = 0; i < 30; i++) begin
      run8(8'($urandom), (i % 4 == 0) ? 8'h80 : 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_random16();
    logic [15:0] a, b, hi_mask;
    int          m;
    for (int i = 0; i < 40; i++) begin
      a       = 16'($urandom);
      b       = 16'($urandom);
      m       = $urandom_range(0, 4);
      hi_mask = (m == 0) ? 16'h0000 : (16'hFFFF << (16 - 4 * m));
      b       = (a & hi_mask) | (b & ~hi_mask);
      run16(a, b, 1'($urandom));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_signed_edges();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    test_chunk_equals_width();
    test_random16();
    checks++;
    if (sb16.size() != 0 || sb8.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left want 0/0", sb16.size(), sb8.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
